// File: rtl/counter_compare_if.sv
// Config port for counter_compare: producer offers a compare value and
// holds it until the consumer's shadow register is free.
interface counter_compare_if #(
  parameter int SIZE = 8
);
  logic            cfg_valid;
  logic [SIZE-1:0] cfg_data;
  logic            cfg_ready;

  modport master (output cfg_valid, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/counter_compare.sv
// Compares a free-running upstream count against a double-buffered compare
// value; produces PWM, match/wrap pulses and a saturating match counter.
module counter_compare #(
  parameter int              SIZE     = 8,
  parameter logic [SIZE-1:0] CMP_INIT = 8'h80,
  parameter int              CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SIZE-1:0]      ctr,
  counter_compare_if.slave     cfg,
  input  logic                 clr,
  output logic                 pwm,
  output logic                 match,
  output logic                 wrap,
  output logic                 pending,
  output logic [CNT_W-1:0]     match_cnt
);

  typedef enum logic {PRIME, RUN} state_t;

  state_t           state_q, state_d;
  logic [SIZE-1:0]  ctr_q, ctr_d;
  logic [SIZE-1:0]  active_q, active_d;
  logic [SIZE-1:0]  shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             pwm_q, pwm_d;
  logic             match_q, match_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

  logic             cfg_take;
  logic             wrap_ev;
  logic [SIZE-1:0]  active_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // The shadow is free whenever nothing is waiting for a wrap.
  assign cfg.cfg_ready = rst | ~pending_q;
  assign cfg_take      = cfg.cfg_valid & ~pending_q;
  assign wrap_ev       = (ctr < ctr_q);
  assign active_next   = (wrap_ev && pending_q) ? shadow_q : active_q;

  always_comb begin
    state_d     = state_q;
    ctr_d       = ctr;
    active_d    = active_q;
    shadow_d    = shadow_q;
    pending_d   = pending_q;
    pwm_d       = pwm_q;
    match_d     = 1'b0;
    wrap_d      = 1'b0;
    match_cnt_d = match_cnt_q;

    if (cfg_take) begin
      shadow_d  = cfg.cfg_data;
      pending_d = 1'b1;
    end

    case (state_q)
      PRIME: begin
        state_d = RUN;
      end
      RUN: begin
        wrap_d   = wrap_ev;
        match_d  = (ctr == active_next) && (ctr != ctr_q);
        pwm_d    = (ctr < active_next);
        active_d = active_next;
        // A transfer cannot coincide with this clear: it needs pending_q low.
        if (wrap_ev && pending_q) pending_d = 1'b0;
      end
      default: state_d = PRIME;
    endcase

    if (clr)          match_cnt_d = '0;
    else if (match_q) match_cnt_d = sat_inc(match_cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PRIME;
      ctr_q       <= '0;
      active_q    <= CMP_INIT;
      shadow_q    <= '0;
      pending_q   <= 1'b0;
      pwm_q       <= 1'b0;
      match_q     <= 1'b0;
      wrap_q      <= 1'b0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ctr_q       <= ctr_d;
      active_q    <= active_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      pwm_q       <= pwm_d;
      match_q     <= match_d;
      wrap_q      <= wrap_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign pwm       = pwm_q;
  assign match     = match_q;
  assign wrap      = wrap_q;
  assign pending   = pending_q;
  assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_counter_compare.sv
// Directed bench for counter_compare: default instance plus a CNT_W=2
// instance sharing the same count and config stimulus.
module tb_counter_compare;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ctr;
  logic       cfg_valid;
  logic [7:0] cfg_data;
  logic       clr, clr2;

  logic        pwm, match, wrap, pending;
  logic [15:0] match_cnt;
  logic        pwm2, match2, wrap2, pending2;
  logic [1:0]  match_cnt2;

  int n_chk = 0;
  int n_err = 0;
  int hi_cnt = 0;

  counter_compare_if #(.SIZE(8)) cfg_if  ();
  counter_compare_if #(.SIZE(8)) cfg_if2 ();

  assign cfg_if.cfg_valid  = cfg_valid;
  assign cfg_if.cfg_data   = cfg_data;
  assign cfg_if2.cfg_valid = cfg_valid;
  assign cfg_if2.cfg_data  = cfg_data;

  counter_compare #(.SIZE(8), .CMP_INIT(8'h80), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ctr(ctr), .cfg(cfg_if), .clr(clr),
    .pwm(pwm), .match(match), .wrap(wrap), .pending(pending),
    .match_cnt(match_cnt)
  );

  counter_compare #(.SIZE(8), .CMP_INIT(8'h80), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .ctr(ctr), .cfg(cfg_if2), .clr(clr2),
    .pwm(pwm2), .match(match2), .wrap(wrap2), .pending(pending2),
    .match_cnt(match_cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int c);
    ctr = 8'(c);
    @(posedge clk);
    #1;
  endtask

  // Walk ctr through lo..hi, checking outputs against compare value act.
  task automatic ramp(input int lo, input int hi, input int act);
    for (int c = lo; c <= hi; c++) begin
      tick(c);
      chk($sformatf("pwm@%0d", c), 32'(pwm), 32'(c < act));
      chk($sformatf("match@%0d", c), 32'(match), 32'(c == act));
      chk($sformatf("wrap@%0d", c), 32'(wrap), 32'd0);
      if (pwm) hi_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; ctr = 8'd0; cfg_valid = 1'b0; cfg_data = 8'd0;
    clr = 1'b0; clr2 = 1'b0;
    tick(0);
    tick(0);
    chk("rst_pwm", 32'(pwm), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
    chk("rst_cnt", 32'(match_cnt), 32'd0);

    rst = 1'b0;
    tick(0);
    chk("prime_pwm", 32'(pwm), 32'd0);
    chk("prime_match", 32'(match), 32'd0);
    chk("prime_wrap", 32'(wrap), 32'd0);

    // Period 1: default compare, stall at 128 for five cycles.
    ramp(1, 127, 128);
    tick(128);
    chk("hold_match0", 32'(match), 32'd1);
    chk("hold_cnt0", 32'(match_cnt), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick(128);
      chk($sformatf("hold_match%0d", i + 1), 32'(match), 32'd0);
    end
    chk("hold_cnt", 32'(match_cnt), 32'd1);
    ramp(129, 255, 128);
    tick(0);
    chk("p1_wrap", 32'(wrap), 32'd1);
    chk("p1_wrap_pwm", 32'(pwm), 32'd1);
    chk("p1_wrap_match", 32'(match), 32'd0);

    // Period 2: write 0x40 at ctr=50; current period still uses 0x80.
    ramp(1, 49, 128);
    cfg_valid = 1'b1; cfg_data = 8'h40;
    tick(50);
    cfg_valid = 1'b0;
    chk("cfg_pending", 32'(pending), 32'd1);
    chk("cfg_ready_low", 32'(cfg_if.cfg_ready), 32'd0);
    ramp(51, 255, 128);
    chk("p2_pending_hold", 32'(pending), 32'd1);
    // Offer a value during the wrap while pending: must be ignored.
    cfg_valid = 1'b1; cfg_data = 8'h10;
    tick(0);
    cfg_valid = 1'b0;
    chk("p2_wrap", 32'(wrap), 32'd1);
    chk("p2_pending_clr", 32'(pending), 32'd0);
    chk("p2_ready", 32'(cfg_if.cfg_ready), 32'd1);
    chk("p2_wrap_pwm", 32'(pwm), 32'd1);

    // Period 3: new compare 0x40 in force.
    hi_cnt = 1;
    ramp(1, 255, 64);
    chk("p3_hi_cnt", 32'(hi_cnt), 32'd64);
    chk("p3_cnt", 32'(match_cnt), 32'd3);
    // Config transfer in the exact wrap cycle with nothing pending.
    cfg_valid = 1'b1; cfg_data = 8'hC0;
    tick(0);
    cfg_valid = 1'b0;
    chk("p3_wrap", 32'(wrap), 32'd1);
    chk("p3_pending", 32'(pending), 32'd1);

    // Period 4: old value 0x40 retained; period 5: 0xC0 applies.
    ramp(1, 255, 64);
    tick(0);
    chk("p4_wrap", 32'(wrap), 32'd1);
    chk("p4_pending", 32'(pending), 32'd0);
    ramp(1, 255, 192);
    chk("p5_cnt", 32'(match_cnt), 32'd5);
    chk("p5_cnt_sat", 32'(match_cnt2), 32'd3);
    tick(0);
    chk("p5_wrap", 32'(wrap), 32'd1);

    // Period 6: clear the narrow counter alongside a match pulse.
    ramp(1, 192, 192);
    clr2 = 1'b1;
    tick(193);
    clr2 = 1'b0;
    chk("clr_cnt2", 32'(match_cnt2), 32'd0);
    chk("noclr_cnt", 32'(match_cnt), 32'd6);
    tick(194);
    chk("clr_cnt2_hold", 32'(match_cnt2), 32'd0);
    ramp(195, 199, 192);
    cfg_valid = 1'b1; cfg_data = 8'h40;
    tick(200);
    cfg_valid = 1'b0;
    ramp(201, 255, 192);
    tick(0);
    chk("p6_wrap", 32'(wrap), 32'd1);

    // Period 7: active=0x40 with 0x20 pending, then reset mid-period.
    ramp(1, 9, 64);
    cfg_valid = 1'b1; cfg_data = 8'h20;
    tick(10);
    cfg_valid = 1'b0;
    chk("p7_pending", 32'(pending), 32'd1);
    ramp(11, 19, 64);
    rst = 1'b1;
    tick(20);
    chk("mrst_pwm", 32'(pwm), 32'd0);
    chk("mrst_match", 32'(match), 32'd0);
    chk("mrst_wrap", 32'(wrap), 32'd0);
    chk("mrst_pending", 32'(pending), 32'd0);
    chk("mrst_ready", 32'(cfg_if.cfg_ready), 32'd1);
    chk("mrst_cnt", 32'(match_cnt), 32'd0);
    rst = 1'b0;
    tick(21);
    chk("mprime_pwm", 32'(pwm), 32'd0);
    chk("mprime_match", 32'(match), 32'd0);
    chk("mprime_wrap", 32'(wrap), 32'd0);
    ramp(22, 255, 128);
    tick(0);
    chk("p8_wrap", 32'(wrap), 32'd1);
    chk("p8_pending", 32'(pending), 32'd0);
    chk("p8_cnt", 32'(match_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/counter_compare.md
Name: counter_compare

Overview:
- Downstream consumer of the free-running `counter` output `ctr`. Compares the live count against a programmable compare value.
- Generates a registered PWM level, a one-cycle match pulse, a one-cycle wrap pulse and a saturating match counter.
- The compare value is written through a valid/ready config port. It is double-buffered: a new value takes effect only at counter wrap, so no glitched PWM periods occur.

Parameters:
- SIZE, 8, width of `ctr` and of compare values; must match the upstream counter.
- CMP_INIT, 8'h80, active compare value after reset (SIZE bits).
- CNT_W, 16, width of the saturating match counter.

Ports:
- clk, input, 1, sole clock; all logic is rising-edge.
- rst, input, 1, reset, synchronous, active-high.
- ctr, input, SIZE, count value from the upstream counter.
- cfg_valid, input, 1, new compare value offered.
- cfg_data, input, SIZE, new compare value.
- cfg_ready, output, 1, shadow register free to accept a value.
- clr, input, 1, synchronous clear of `match_cnt`.
- pwm, output, 1, registered (ctr < active compare).
- match, output, 1, one-cycle pulse on entering ctr == active.
- wrap, output, 1, one-cycle pulse when the count wraps.
- pending, output, 1, shadow value waiting for the next wrap.
- match_cnt, output, CNT_W, saturating count of match pulses.

Behaviour:
- Reset (rst=1 at a clk edge) sets:
  - state=PRIME, ctr_q=0, active=CMP_INIT, shadow=0
  - pending=0, pwm=0, match=0, wrap=0, match_cnt=0
  - cfg_ready=1 while in reset.
- State machine, two states:
  - PRIME: first cycle after reset. Loads ctr_q<=ctr and produces no match/wrap/pwm update. Unconditional transition to RUN.
  - RUN: normal operation. Only rst leaves RUN.
- In RUN, each cycle:
  - ctr_q<=ctr.
  - wrap<=(ctr < ctr_q), unsigned compare; detects both a natural wrap and an upstream reset to 0.
  - match<=(ctr == active_next) && (ctr != ctr_q). This gives exactly one pulse per entry into the compare value; a stalled counter holding the value yields no repeat pulses.
  - pwm<=(ctr < active_next).
  - Latency of all three outputs: 1 cycle from ctr.
- active_next:
  - Equals shadow when (ctr < ctr_q) && pending; the new value applies to the first count of the new period.
  - Otherwise equals active.
  - active<=active_next.
- Config handshake:
  - cfg_ready = !pending (combinational from the register).
  - Transfer when cfg_valid && cfg_ready: shadow<=cfg_data, pending<=1.
  - On a wrap with pending=1, pending<=0 and active<=shadow.
  - Wrap and transfer in the same cycle with pending=0: the value is captured, pending=1, and it applies at the next wrap, not the current one.
  - Wrap and pending=1 in the same cycle: cfg_ready=0 that cycle, so no transfer; cfg_ready returns to 1 the following cycle.
  - cfg_valid with cfg_ready=0 is ignored; the producer holds cfg_data until the transfer.
  - cfg is accepted in PRIME.
- Compare value edge cases:
  - active=0 gives pwm constant 0.
  - active=2^SIZE-1 gives pwm=1 except at the max count.
  - No special-casing is required.
- match_cnt:
  - clr has priority: match_cnt<=0.
  - Otherwise it increments when match is asserted (the registered pulse), saturating at 2^CNT_W-1.
- Reset mid-operation:
  - Any pending shadow is discarded.
  - active returns to CMP_INIT.
  - One PRIME cycle follows before events resume.

Test Plan:
- Reset, then ctr ramps 0..255..0 with SIZE=8 and default CMP_INIT:
  - pwm=1 for ctr 0..127 and 0 for 128..255, delayed one cycle.
  - match pulses once, the cycle after ctr=128.
  - wrap pulses the cycle after ctr=0 follows 255.
  - No pulses in the PRIME cycle.
- Write cfg_data=8'h40 mid-period (ctr=50):
  - cfg_ready drops and pending=1.
  - The current period still matches at 128.
  - After wrap, pending=0, match occurs at ctr=64 and the pwm high phase is 64 counts.
- Hold ctr at 128 for 5 cycles: match is exactly one pulse; match_cnt increases by 1.
- Assert cfg_valid in the exact cycle ctr goes 255->0 with pending=0: value is accepted, old active is retained for this period, and the new value applies after the following wrap.
- CNT_W=2: run 5 periods and read match_cnt=3 (saturated); assert clr alongside a match, then match_cnt=0.
- Assert rst while pending=1 and active=8'h40: afterwards active=8'h80, pending=0, cfg_ready=1, outputs 0, and the first wrap/match occurs only after the PRIME cycle.
